// File: rtl/altmemddr_phy_pll_phs_shft_arbiter.sv
// altmemddr_phy_pll_phs_shft_arbiter
//   Shares the single PLL dynamic phase-shift port between the sequencer
//   (seq_*) and a user/debug requester (usr_*). A granted request runs
//   seq/usr_steps phase steps. Each step is one pll_start_reconfig strobe
//   followed by a full high/low cycle of the (synchronised) phs_shft_busy.
//   The owner's ack is pulsed once the operation completes.
//
// Ports
//   seq_clk, reset_seq         single clock, synchronous active-high reset
//   seq_req/sel/inc_dec_n/steps  sequencer request and its fields; seq_ack pulse
//   usr_req/sel/inc_dec_n/steps  user request and its fields;      usr_ack pulse
//   phs_shft_busy              PLL busy (asynchronous, synchronised here)
//   pll_start_reconfig         1-cycle step strobe to the PLL
//   pll_select, pll_inc_dec_n  latched select/direction of the current owner
//   arb_busy, arb_owner        not-idle flag; owner (0=seq, 1=usr)
//   err_timeout                sticky busy-watchdog error
//
// Optional feature
//   PLL_PHS_ARB_TIMEOUT_EN: busy watchdog of TIMEOUT_CYCLES in the WAIT
//   states. Undefined: WAIT states wait indefinitely, err_timeout is 0.
module altmemddr_phy_pll_phs_shft_arbiter #(
  parameter int CLOCK_INDEX_WIDTH = 3,
  parameter int STEP_WIDTH        = 7,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         seq_clk,
  input  logic                         reset_seq,
  input  logic                         seq_req,
  input  logic [CLOCK_INDEX_WIDTH-1:0] seq_sel,
  input  logic                         seq_inc_dec_n,
  input  logic [STEP_WIDTH-1:0]        seq_steps,
  output logic                         seq_ack,
  input  logic                         usr_req,
  input  logic [CLOCK_INDEX_WIDTH-1:0] usr_sel,
  input  logic                         usr_inc_dec_n,
  input  logic [STEP_WIDTH-1:0]        usr_steps,
  output logic                         usr_ack,
  input  logic                         phs_shft_busy,
  output logic                         pll_start_reconfig,
  output logic [CLOCK_INDEX_WIDTH-1:0] pll_select,
  output logic                         pll_inc_dec_n,
  output logic                         arb_busy,
  output logic                         arb_owner,
  output logic                         err_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [1:0]                   busy_sync;
  logic                         busy_s;
  logic                         last_owner;
  logic                         last_owner_nxt;
  logic                         owner_nxt;
  logic                         dir_nxt;
  logic [CLOCK_INDEX_WIDTH-1:0] sel_nxt;
  logic [STEP_WIDTH-1:0]        step_cnt;
  logic [STEP_WIDTH-1:0]        step_cnt_nxt;
  logic                         grant_usr;
  logic                         tmo_expired;

  assign busy_s = busy_sync[1];

  // usr wins when it is alone, or on a tie when seq was served last.
  assign grant_usr = usr_req && (!seq_req || !last_owner);

  always_comb begin
    state_nxt      = state;
    step_cnt_nxt   = step_cnt;
    owner_nxt      = arb_owner;
    last_owner_nxt = last_owner;
    sel_nxt        = pll_select;
    dir_nxt        = pll_inc_dec_n;
    unique case (state)
      IDLE: begin
        if (seq_req || usr_req) begin
          owner_nxt      = grant_usr;
          last_owner_nxt = grant_usr;
          sel_nxt        = grant_usr ? usr_sel       : seq_sel;
          dir_nxt        = grant_usr ? usr_inc_dec_n : seq_inc_dec_n;
          step_cnt_nxt   = grant_usr ? usr_steps     : seq_steps;
          state_nxt      = (step_cnt_nxt == '0) ? DONE : START;
        end
      end
      START: state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (busy_s) begin
          state_nxt = WAIT_LO;
        end else if (tmo_expired) begin
          step_cnt_nxt = '0;
          state_nxt    = DONE;
        end
      end
      WAIT_LO: begin
        if (!busy_s) begin
          // step_cnt >= 1 here: zero-step grants bypass the step loop.
          step_cnt_nxt = step_cnt - STEP_WIDTH'(1);
          state_nxt    = (step_cnt == STEP_WIDTH'(1)) ? DONE : START;
        end else if (tmo_expired) begin
          step_cnt_nxt = '0;
          state_nxt    = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so that they line up
  // with the state they describe.
  always_ff @(posedge seq_clk) begin
    if (reset_seq) begin
      state              <= IDLE;
      busy_sync          <= 2'b11;
      step_cnt           <= '0;
      last_owner         <= 1'b1;
      arb_owner          <= 1'b0;
      pll_select         <= '0;
      pll_inc_dec_n      <= 1'b0;
      pll_start_reconfig <= 1'b0;
      arb_busy           <= 1'b0;
      seq_ack            <= 1'b0;
      usr_ack            <= 1'b0;
    end else begin
      state              <= state_nxt;
      busy_sync          <= {busy_sync[0], phs_shft_busy};
      step_cnt           <= step_cnt_nxt;
      last_owner         <= last_owner_nxt;
      arb_owner          <= owner_nxt;
      pll_select         <= sel_nxt;
      pll_inc_dec_n      <= dir_nxt;
      pll_start_reconfig <= (state_nxt == START);
      arb_busy           <= (state_nxt != IDLE);
      seq_ack            <= (state_nxt == DONE) && !owner_nxt;
      usr_ack            <= (state_nxt == DONE) && owner_nxt;
    end
  end

`ifdef PLL_PHS_ARB_TIMEOUT_EN
  localparam int TMO_W = 1 + $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt;
  logic             in_wait;
  logic             wait_met;

  assign in_wait     = (state == WAIT_HI) || (state == WAIT_LO);
  assign wait_met    = (state == WAIT_HI) ? busy_s : !busy_s;
  assign tmo_expired = in_wait && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

  // Any state change clears the counter, which covers entry into either
  // WAIT state; it cannot wrap because expiry forces an exit.
  always_ff @(posedge seq_clk) begin
    if (reset_seq) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        tmo_cnt <= '0;
      end else if (in_wait) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (tmo_expired && !wait_met) begin
        err_timeout <= 1'b1;
      end
    end
  end
`else
  assign tmo_expired = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_altmemddr_phy_pll_phs_shft_arbiter.sv
// Testbench for altmemddr_phy_pll_phs_shft_arbiter: table of transaction
// vectors, a few hand-written corner sequences, and randomized transactions
// checked against a transaction-level round-robin model.
module tb_altmemddr_phy_pll_phs_shft_arbiter;

  logic       clk = 1'b0;
  logic       reset_seq;
  logic       seq_req, usr_req;
  logic [2:0] seq_sel, usr_sel;
  logic       seq_inc_dec_n, usr_inc_dec_n;
  logic [6:0] seq_steps, usr_steps;
  logic       seq_ack, usr_ack;
  logic       phs_shft_busy;
  logic       pll_start_reconfig;
  logic [2:0] pll_select;
  logic       pll_inc_dec_n;
  logic       arb_busy, arb_owner, err_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int rise_dly = 2;
  int hi_len   = 4;
  bit busy_en  = 1'b1;
  bit m_last   = 1'b1;   // model: last served owner (1 = usr after reset)

  typedef struct {
    bit sr, ur;
    logic [2:0] ssel; bit sdir; logic [6:0] sst;
    logic [2:0] usel; bit udir; logic [6:0] ust;
    int udly;            // >0: usr_req raised when seq strobe #udly is seen
    int rise, hi;
    bit exp_first_usr; int exp_ns, exp_nu;
  } vec_t;

  typedef struct {
    bit first_usr; int ns, nu, lat; bit ok, tmo, idle;
  } res_t;

  always #5 clk = ~clk;

  altmemddr_phy_pll_phs_shft_arbiter #(
    .CLOCK_INDEX_WIDTH(3),
    .STEP_WIDTH(7),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .seq_clk(clk),
    .reset_seq(reset_seq),
    .seq_req(seq_req),
    .seq_sel(seq_sel),
    .seq_inc_dec_n(seq_inc_dec_n),
    .seq_steps(seq_steps),
    .seq_ack(seq_ack),
    .usr_req(usr_req),
    .usr_sel(usr_sel),
    .usr_inc_dec_n(usr_inc_dec_n),
    .usr_steps(usr_steps),
    .usr_ack(usr_ack),
    .phs_shft_busy(phs_shft_busy),
    .pll_start_reconfig(pll_start_reconfig),
    .pll_select(pll_select),
    .pll_inc_dec_n(pll_inc_dec_n),
    .arb_busy(arb_busy),
    .arb_owner(arb_owner),
    .err_timeout(err_timeout)
  );

  // PLL busy model: after each strobe, rise after rise_dly cycles, stay high hi_len cycles.
  initial begin
    phs_shft_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (pll_start_reconfig && busy_en) begin
        repeat (rise_dly) @(negedge clk);
        phs_shft_busy = 1'b1;
        repeat (hi_len) @(negedge clk);
        phs_shft_busy = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input int sr, ur, ssel, sdir, sst, usel, udir, ust,
                              udly, rise, hi, efu, ens, enu);
    vec_t v;
    v.sr = sr[0]; v.ur = ur[0];
    v.ssel = 3'(ssel); v.sdir = sdir[0]; v.sst = 7'(sst);
    v.usel = 3'(usel); v.udir = udir[0]; v.ust = 7'(ust);
    v.udly = udly; v.rise = rise; v.hi = hi;
    v.exp_first_usr = efu[0]; v.exp_ns = ens; v.exp_nu = enu;
    return v;
  endfunction

  // Round-robin model at transaction level.
  task automatic model_txn(input vec_t v, output bit first_usr);
    if (v.sr && v.ur && v.udly == 0) begin
      first_usr = !m_last;        // both served; the loser is served last, so m_last keeps its value
    end else if (v.sr && v.ur) begin
      first_usr = 1'b0;           // usr arrives mid-operation, served after seq
      m_last    = 1'b1;
    end else begin
      first_usr = v.ur;
      m_last    = v.ur;
    end
  endtask

  task automatic run_txn(input vec_t v, output res_t r);
    bit ps, pu, in_s, in_u, got_first;
    int cyc;
    r = '{default: 0};
    r.ok = 1'b1; r.lat = -1;
    ps = v.sr; pu = v.ur; in_s = 0; in_u = 0; got_first = 0; cyc = 0;
    rise_dly = v.rise; hi_len = v.hi;
    @(negedge clk);
    seq_sel = v.ssel; seq_inc_dec_n = v.sdir; seq_steps = v.sst; seq_req = v.sr;
    usr_sel = v.usel; usr_inc_dec_n = v.udir; usr_steps = v.ust;
    usr_req = v.ur && (v.udly == 0);
    while ((ps || pu) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (r.lat < 0 && (pll_start_reconfig || seq_ack || usr_ack)) r.lat = cyc;
      if (pll_start_reconfig) begin
        if (!arb_busy) r.ok = 1'b0;
        if (arb_owner) begin
          r.nu++;
          if (in_s || pll_select != v.usel || pll_inc_dec_n != v.udir) r.ok = 1'b0;
          in_u = 1'b1;
        end else begin
          r.ns++;
          if (in_u || pll_select != v.ssel || pll_inc_dec_n != v.sdir) r.ok = 1'b0;
          in_s = 1'b1;
          if (v.ur && v.udly > 0 && r.ns == v.udly) usr_req = 1'b1;
        end
      end
      if (seq_ack) begin
        if (!ps || arb_owner || usr_ack || !arb_busy) r.ok = 1'b0;
        if (!got_first) begin r.first_usr = 1'b0; got_first = 1'b1; end
        ps = 0; in_s = 0; seq_req = 1'b0;
      end
      if (usr_ack) begin
        if (!pu || !arb_owner || !arb_busy) r.ok = 1'b0;
        if (!got_first) begin r.first_usr = 1'b1; got_first = 1'b1; end
        pu = 0; in_u = 0; usr_req = 1'b0;
      end
    end
    r.tmo = ps || pu;
    seq_req = 1'b0; usr_req = 1'b0;
    @(negedge clk);
    r.idle = !arb_busy && !seq_ack && !usr_ack;
  endtask

  task automatic check_txn(input string tag, input res_t r, input bit efu, input int ens, input int enu);
    check({tag, " first"}, r.first_usr, efu);
    check({tag, " seq strobes"}, r.ns, ens);
    check({tag, " usr strobes"}, r.nu, enu);
    check({tag, " sel/dir/order"}, r.ok, 1);
    check({tag, " timeout"}, r.tmo, 0);
    check({tag, " latency"}, r.lat, 1);
    check({tag, " idle after"}, r.idle, 1);
  endtask

  vec_t vecs[7];

  initial begin
    res_t r;
    bit   pf;
    int   acks, n_str, str_cyc, ack_cyc;
    bit   got;

    reset_seq = 1'b1;
    seq_req = 0; usr_req = 0; seq_sel = '0; usr_sel = '0;
    seq_inc_dec_n = 0; usr_inc_dec_n = 0; seq_steps = '0; usr_steps = '0;
    repeat (3) @(negedge clk);
    check("reset strobe", pll_start_reconfig, 0);
    check("reset busy", arb_busy, 0);
    check("reset owner", arb_owner, 0);
    check("reset select", pll_select, 0);
    check("reset dir", pll_inc_dec_n, 0);
    check("reset seq_ack", seq_ack, 0);
    check("reset usr_ack", usr_ack, 0);
    check("reset err", err_timeout, 0);
    reset_seq = 1'b0;
    m_last = 1'b1;

    //             sr ur ssel sdir sst usel udir ust udly rise hi efu ens enu
    vecs[0] = mk(1, 1, 1, 1, 1, 6, 0, 1, 0, 1, 2, 0, 1, 1);  // first tie after reset: seq
    vecs[1] = mk(1, 0, 2, 1, 3, 0, 0, 0, 0, 2, 4, 0, 3, 0);  // 3 steps, sel 2, increment
    vecs[2] = mk(1, 1, 3, 0, 2, 4, 1, 1, 0, 2, 3, 1, 2, 1);  // tie after seq served: usr
    vecs[3] = mk(0, 1, 0, 0, 0, 5, 1, 0, 0, 1, 1, 1, 0, 0);  // usr zero steps: ack only
    vecs[4] = mk(1, 1, 7, 0, 5, 1, 1, 2, 2, 1, 3, 0, 5, 2);  // usr arrives during seq step 2
    vecs[5] = mk(1, 1, 2, 1, 0, 3, 0, 0, 0, 1, 1, 0, 0, 0);  // zero-step tie, last=usr: seq
    vecs[6] = mk(0, 1, 0, 0, 0, 2, 0, 4, 0, 3, 1, 1, 0, 4);
    for (int i = 0; i < 7; i++) begin
      model_txn(vecs[i], pf);
      run_txn(vecs[i], r);
      check_txn($sformatf("row%0d", i), r, vecs[i].exp_first_usr, vecs[i].exp_ns, vecs[i].exp_nu);
    end

    // Reset while in WAIT_LO drops the operation without an ack.
    rise_dly = 1; hi_len = 6;
    @(negedge clk);
    seq_sel = 3'd5; seq_inc_dec_n = 1'b1; seq_steps = 7'd3; seq_req = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (phs_shft_busy) got = 1;
    end
    check("midrst busy seen", got, 1);
    repeat (3) @(negedge clk);
    reset_seq = 1'b1; seq_req = 1'b0;
    @(negedge clk);
    reset_seq = 1'b0;
    check("midrst strobe", pll_start_reconfig, 0);
    check("midrst busy", arb_busy, 0);
    check("midrst select", pll_select, 0);
    check("midrst dir", pll_inc_dec_n, 0);
    check("midrst owner", arb_owner, 0);
    check("midrst acks", seq_ack + usr_ack, 0);
    acks = 0;
    repeat (12) begin
      @(negedge clk);
      acks += int'(seq_ack) + int'(usr_ack);
    end
    check("midrst no late ack", acks, 0);
    m_last = 1'b1;
    run_txn(mk(1, 0, 4, 0, 1, 0, 0, 0, 0, 2, 2, 0, 1, 0), r);
    check_txn("after midrst", r, 0, 1, 0);

    // Randomized transactions against the model.
    for (int it = 0; it < 30; it++) begin
      vec_t v;
      int   k;
      k = $urandom_range(0, 2);
      v = mk(int'(k != 1), int'(k != 0), $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 5), 0, $urandom_range(1, 3), $urandom_range(1, 4), 0, 0, 0);
      if (v.sr && v.ur && v.sst > 0 && $urandom_range(0, 3) == 0)
        v.udly = $urandom_range(1, int'(v.sst));
      model_txn(v, pf);
      run_txn(v, r);
      check_txn($sformatf("rand%0d", it), r, pf, v.sr ? int'(v.sst) : 0, v.ur ? int'(v.ust) : 0);
    end

    // Busy stuck low after the first strobe.
    busy_en = 1'b0;
    @(negedge clk);
    seq_sel = 3'd3; seq_inc_dec_n = 1'b0; seq_steps = 7'd2; seq_req = 1'b1;
    n_str = 0; acks = 0; str_cyc = -1; ack_cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (pll_start_reconfig) begin
        n_str++;
        if (str_cyc < 0) str_cyc = c;
      end
      if (seq_ack) begin
        acks++; ack_cyc = c; seq_req = 1'b0;
      end
    end
    check("stuck strobes", n_str, 1);
`ifdef PLL_PHS_ARB_TIMEOUT_EN
    check("stuck acks", acks, 1);
    check("stuck err", err_timeout, 1);
    check("stuck ack delay", int'(ack_cyc - str_cyc >= 16 && ack_cyc - str_cyc <= 20), 1);
    check("stuck idle", arb_busy, 0);
`else
    check("stuck acks", acks, 0);
    check("stuck err", err_timeout, 0);
    check("stuck still busy", arb_busy, 1);
`endif
    reset_seq = 1'b1; seq_req = 1'b0;
    @(negedge clk);
    reset_seq = 1'b0;
    check("final rst busy", arb_busy, 0);
    check("final rst err", err_timeout, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
